// File: rtl/pad_pwr_pkg.sv
// Power-state encodings and sequencer FSM states, shared by the pad sequencer and pad_controller.
// Pure declarations: no latency, no flow control.
package pad_pwr_pkg;

  localparam logic [1:0] PS_ACTIVE     = 2'b00;
  localparam logic [1:0] PS_SLEEP      = 2'b01;
  localparam logic [1:0] PS_DEEP_SLEEP = 2'b10;
  localparam logic [1:0] PS_DEEP_WAKE  = 2'b11;

  typedef enum logic [2:0] {
    S_ACTIVE,
    S_SLEEP,
    S_DS_ISO,
    S_DEEP,
    S_RAMP
  } pwr_fsm_e;

  // Isolation and deep sleep both present DEEP_SLEEP to the pads; only the rail differs.
  function automatic logic [1:0] ps_of(input pwr_fsm_e s);
    logic [1:0] ps;
    ps = PS_DEEP_WAKE;
    case (s)
      S_ACTIVE: ps = PS_ACTIVE;
      S_SLEEP:  ps = PS_SLEEP;
      S_DS_ISO: ps = PS_DEEP_SLEEP;
      S_DEEP:   ps = PS_DEEP_SLEEP;
      default:  ps = PS_DEEP_WAKE;
    endcase
    return ps;
  endfunction

endpackage

// File: rtl/pad_pwr_ramp_timer.sv
// Rail ramp qualifier: pg_cnt counts consecutive vdd_pg-high cycles, to_cnt counts ramp cycles.
// Flags are registered-count compares; start clears both, counters saturate, no backpressure.
module pad_pwr_ramp_timer
  import pad_pwr_pkg::*;
#(
  parameter int unsigned RAMP_CYCLES = 16,
  parameter int unsigned PG_TIMEOUT  = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic vdd_pg,
  output logic ramp_ok,
  output logic timeout
);

  localparam int CW = $clog2(PG_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(PG_TIMEOUT);
  localparam logic [CW-1:0] RAMP_LIM = CW'(RAMP_CYCLES);

  logic [CW-1:0] pg_cnt_q, pg_cnt_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    pg_cnt_d = pg_cnt_q;
    to_cnt_d = to_cnt_q;
    if (start) begin
      pg_cnt_d = '0;
      to_cnt_d = '0;
    end else if (run) begin
      // A single low cycle disqualifies the rail: qualification restarts from zero.
      if (!vdd_pg) begin
        pg_cnt_d = '0;
      end else if (pg_cnt_q != CNT_MAX) begin
        pg_cnt_d = pg_cnt_q + CW'(1);
      end
      if (to_cnt_q != CNT_MAX) begin
        to_cnt_d = to_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      pg_cnt_q <= pg_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign ramp_ok = (pg_cnt_q >= RAMP_LIM);
  assign timeout = (to_cnt_q >= CNT_MAX);

endmodule

// File: rtl/pad_power_sequencer.sv
// Pad power-mode sequencer: registered outputs change on the accept/transition edge; req_ready is
// combinational and low outside stable modes. PAD_SEQ_WAKE_EVT_EN enables wake_evt exit from deep sleep.
module pad_power_sequencer
  import pad_pwr_pkg::*;
#(
  parameter int unsigned RAMP_CYCLES = 16,
  parameter int unsigned PG_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_state,
  output logic       req_ready,
  input  logic       wake_evt,
  input  logic       vdd_pg,
  output logic [1:0] power_state,
  output logic       VDD_ON,
  output logic       enter_active,
  output logic       oe_allow,
  output logic       done,
  output logic       err
);

  pwr_fsm_e   state_q, state_d;
  logic [1:0] power_state_q, power_state_d;
  logic       vdd_on_q, vdd_on_d;
  logic       enter_active_q, enter_active_d;
  logic       oe_allow_q, oe_allow_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic start, ramp_ok, timeout, wake, accept, stable;

`ifdef PAD_SEQ_WAKE_EVT_EN
  assign wake = wake_evt && (state_q == S_DEEP);
`else
  logic unused_wake_evt;
  assign unused_wake_evt = wake_evt;
  assign wake            = 1'b0;
`endif

  assign stable    = (state_q == S_ACTIVE) || (state_q == S_SLEEP) || (state_q == S_DEEP);
  assign req_ready = stable && !wake;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d        = state_q;
    enter_active_d = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;
    case (state_q)
      S_ACTIVE, S_SLEEP: begin
        if (accept) begin
          if (req_state == ps_of(state_q)) begin
            done_d = 1'b1;
          end else begin
            case (req_state)
              PS_ACTIVE: begin
                state_d        = S_ACTIVE;
                enter_active_d = 1'b1;
                done_d         = 1'b1;
              end
              PS_SLEEP: begin
                state_d = S_SLEEP;
                done_d  = 1'b1;
              end
              PS_DEEP_SLEEP: state_d = S_DS_ISO;
              default:       err_d   = 1'b1;
            endcase
          end
        end
      end
      // Pads see DEEP_SLEEP for a full cycle before the rail is dropped.
      S_DS_ISO: begin
        state_d = S_DEEP;
        done_d  = 1'b1;
      end
      S_DEEP: begin
        if (wake) begin
          state_d = S_RAMP;
        end else if (accept) begin
          if (req_state == PS_DEEP_WAKE) begin
            err_d = 1'b1;
          end else if (req_state == PS_DEEP_SLEEP) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RAMP;
          end
        end
      end
      S_RAMP: begin
        if (ramp_ok) begin
          state_d        = S_ACTIVE;
          enter_active_d = 1'b1;
          done_d         = 1'b1;
        end else if (timeout) begin
          state_d = S_DEEP;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_RAMP;
    endcase

    start         = (state_d == S_RAMP) && (state_q != S_RAMP);
    power_state_d = ps_of(state_d);
    vdd_on_d      = (state_d != S_DEEP);
    oe_allow_d    = (state_d == S_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RAMP;
      power_state_q  <= PS_DEEP_WAKE;
      vdd_on_q       <= 1'b1;
      enter_active_q <= 1'b0;
      oe_allow_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      power_state_q  <= power_state_d;
      vdd_on_q       <= vdd_on_d;
      enter_active_q <= enter_active_d;
      oe_allow_q     <= oe_allow_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  pad_pwr_ramp_timer #(
    .RAMP_CYCLES(RAMP_CYCLES),
    .PG_TIMEOUT (PG_TIMEOUT)
  ) u_ramp_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .run    (state_q == S_RAMP),
    .vdd_pg (vdd_pg),
    .ramp_ok(ramp_ok),
    .timeout(timeout)
  );

  assign power_state  = power_state_q;
  assign VDD_ON       = vdd_on_q;
  assign enter_active = enter_active_q;
  assign oe_allow     = oe_allow_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_pad_power_sequencer.sv
// Table-driven bench for pad_power_sequencer with a scoreboard queue of expected outputs.
module tb_pad_power_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_state = 2'b00;
  logic       req_ready;
  logic       wake_evt = 1'b0;
  logic       vdd_pg = 1'b1;
  logic [1:0] power_state;
  logic       VDD_ON, enter_active, oe_allow, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rv;
    logic [1:0] rs;
    logic       wk;
    logic       pg;
    logic       rdy;
    logic [1:0] ps;
    logic       von, ea, oe, dn, er;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[14];

  always #5 clk = ~clk;

  pad_power_sequencer #(.RAMP_CYCLES(16), .PG_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_state(req_state),
    .req_ready(req_ready), .wake_evt(wake_evt), .vdd_pg(vdd_pg),
    .power_state(power_state), .VDD_ON(VDD_ON), .enter_active(enter_active),
    .oe_allow(oe_allow), .done(done), .err(err)
  );

  function automatic vec_t mk(input logic rv, input logic [1:0] rs, input logic wk, input logic pg,
                              input logic rdy, input logic [1:0] ps, input logic von,
                              input logic ea, input logic oe, input logic dn, input logic er);
    vec_t v;
    v.rv = rv; v.rs = rs; v.wk = wk; v.pg = pg; v.rdy = rdy;
    v.ps = ps; v.von = von; v.ea = ea; v.oe = oe; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b ({ps,von,ea,oe,done,err} or rdy)", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check req_ready, push expectation, compare after the edge.
  task automatic step(input vec_t v, input string nm);
    vec_t e;
    @(negedge clk);
    req_valid = v.rv; req_state = v.rs; wake_evt = v.wk; vdd_pg = v.pg;
    #1;
    chk({nm, "_rdy"}, {6'b0, req_ready}, {6'b0, v.rdy});
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(nm, {power_state, VDD_ON, enter_active, oe_allow, done, err},
        {e.ps, e.von, e.ea, e.oe, e.dn, e.er});
  endtask

  task automatic ramp(input int n, input logic pg, input string nm);
    for (int i = 0; i < n; i++) step(mk(0, 2'b00, 0, pg, 0, 2'b11, 1, 0, 0, 0, 0), nm);
  endtask

  initial begin
    tbl[0]  = mk(1, 2'b01, 0, 1, 1, 2'b01, 1, 0, 0, 1, 0);
    tbl[1]  = mk(0, 2'b00, 0, 1, 1, 2'b01, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 2'b01, 0, 1, 1, 2'b01, 1, 0, 0, 1, 0);
    tbl[3]  = mk(1, 2'b11, 0, 1, 1, 2'b01, 1, 0, 0, 0, 1);
    tbl[4]  = mk(1, 2'b00, 0, 1, 1, 2'b00, 1, 1, 1, 1, 0);
    tbl[5]  = mk(0, 2'b00, 0, 1, 1, 2'b00, 1, 0, 1, 0, 0);
    tbl[6]  = mk(1, 2'b11, 0, 1, 1, 2'b00, 1, 0, 1, 0, 1);
    tbl[7]  = mk(1, 2'b00, 0, 1, 1, 2'b00, 1, 0, 1, 1, 0);
    tbl[8]  = mk(1, 2'b01, 0, 1, 1, 2'b01, 1, 0, 0, 1, 0);
    tbl[9]  = mk(1, 2'b10, 0, 1, 1, 2'b10, 1, 0, 0, 0, 0);
    tbl[10] = mk(1, 2'b00, 0, 1, 0, 2'b10, 0, 0, 0, 1, 0);
    tbl[11] = mk(0, 2'b00, 0, 1, 1, 2'b10, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 2'b10, 0, 1, 1, 2'b10, 0, 0, 0, 1, 0);
    tbl[13] = mk(1, 2'b11, 0, 1, 1, 2'b10, 0, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {power_state, VDD_ON, enter_active, oe_allow, done, err}, 7'b11_1_0000);
    chk("reset_rdy", {6'b0, req_ready}, 7'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    ramp(16, 1, "boot_ramp");
    step(mk(0, 2'b00, 0, 1, 0, 2'b00, 1, 1, 1, 1, 0), "boot_active");
    step(mk(0, 2'b00, 0, 1, 1, 2'b00, 1, 0, 1, 0, 0), "boot_single_pulse");

    for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("tbl%0d", i));

    step(mk(1, 2'b00, 0, 1, 1, 2'b11, 1, 0, 0, 0, 0), "wake_accept");
    ramp(16, 1, "wake_ramp");
    step(mk(0, 2'b00, 0, 1, 0, 2'b00, 1, 1, 1, 1, 0), "wake_active");
    step(mk(0, 2'b00, 0, 1, 1, 2'b00, 1, 0, 1, 0, 0), "wake_single_pulse");

    step(mk(1, 2'b10, 0, 1, 1, 2'b10, 1, 0, 0, 0, 0), "act2ds_iso");
    step(mk(0, 2'b00, 0, 1, 0, 2'b10, 0, 0, 0, 1, 0), "act2ds_deep");

    // SLEEP target from deep sleep completes to ACTIVE; pg glitch restarts qualification.
    step(mk(1, 2'b01, 0, 1, 1, 2'b11, 1, 0, 0, 0, 0), "pgdrop_accept");
    ramp(10, 1, "pgdrop_pre");
    ramp(3, 0, "pgdrop_low");
    ramp(16, 1, "pgdrop_requal");
    step(mk(0, 2'b00, 0, 1, 0, 2'b00, 1, 1, 1, 1, 0), "pgdrop_active");

    step(mk(1, 2'b10, 0, 1, 1, 2'b10, 1, 0, 0, 0, 0), "to_ds_iso");
    step(mk(0, 2'b00, 0, 1, 0, 2'b10, 0, 0, 0, 1, 0), "to_ds_deep");
    step(mk(1, 2'b00, 0, 0, 1, 2'b11, 1, 0, 0, 0, 0), "tmo_accept");
    ramp(64, 0, "tmo_ramp");
    step(mk(0, 2'b00, 0, 0, 0, 2'b10, 0, 0, 0, 0, 1), "tmo_abort");
    step(mk(0, 2'b00, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0), "tmo_deep_hold");

`ifdef PAD_SEQ_WAKE_EVT_EN
    step(mk(1, 2'b10, 1, 1, 0, 2'b11, 1, 0, 0, 0, 0), "wake_evt_prio");
    ramp(16, 1, "wake_evt_ramp");
    step(mk(0, 2'b00, 0, 1, 0, 2'b00, 1, 1, 1, 1, 0), "wake_evt_active");
`else
    step(mk(1, 2'b10, 1, 1, 1, 2'b10, 0, 0, 0, 1, 0), "wake_evt_ignored_req");
    step(mk(0, 2'b00, 1, 1, 1, 2'b10, 0, 0, 0, 0, 0), "wake_evt_ignored");
`endif

    @(negedge clk);
    req_valid = 1'b0; wake_evt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midop_reset_outs", {power_state, VDD_ON, enter_active, oe_allow, done, err}, 7'b11_1_0000);
    chk("midop_reset_rdy", {6'b0, req_ready}, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
